i2s_tx: RTL and testbench

//  I2S master transmitter: derives bclk/ws from sys_clk and serialises stereo PCM, MSB first.

---
 rtl/i2s_tx.sv | 162 ++++++++++++++++
 tb/tb_i2s_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// I2S master transmitter: derives bclk/ws from sys_clk and shifts stereo PCM out MSB first.
// A one-entry holding buffer with a valid/ready handshake feeds each frame.
module i2s_tx #(
  parameter int WORD_LENGTH = 24,
  parameter int SLOT_BITS   = 32,
  parameter int BCLK_DIV    = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_rst,
  input  logic                   i_tx_en,
  input  logic                   i_tx_valid,
  output logic                   o_tx_ready,
  input  logic [WORD_LENGTH-1:0] i_tx_left_data,
  input  logic [WORD_LENGTH-1:0] i_tx_right_data,
  output logic                   o_tx_underrun,
  output logic                   o_bclk,
  output logic                   o_ws,
  output logic                   o_sdata
);

  // state  | meaning
  // S_IDLE | lines parked low, waiting for tx_en
  // S_RUN  | bclk running, one update event per bclk falling edge

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int POS_W      = $clog2(FRAME_BITS);
  localparam int PX_W       = POS_W + 1;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_BITS - 1);
  localparam logic [PX_W-1:0]  L_END    = PX_W'(WORD_LENGTH);
  localparam logic [PX_W-1:0]  R_BEG    = PX_W'(SLOT_BITS);
  localparam logic [PX_W-1:0]  R_END    = PX_W'(SLOT_BITS + WORD_LENGTH);
  localparam logic [PX_W-1:0]  WS_BEG   = PX_W'(SLOT_BITS - 1);
  localparam logic [PX_W-1:0]  WS_END   = PX_W'(FRAME_BITS - 2);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DIV_W-1:0]       r_div;
  logic [POS_W-1:0]       r_pos;
  logic                   r_bclk;
  logic                   r_ws;
  logic                   r_sdata;
  logic                   r_underrun;
  logic                   r_buf_full;
  logic [WORD_LENGTH-1:0] r_buf_l;
  logic [WORD_LENGTH-1:0] r_buf_r;
  logic [WORD_LENGTH-1:0] r_sh_l;
  logic [WORD_LENGTH-1:0] r_sh_r;

  logic                   w_div_wrap;
  logic                   w_event;
  logic                   w_frame_start;
  logic                   w_accept;
  logic                   w_in_left;
  logic                   w_in_right;
  logic                   w_ws_nxt;
  logic                   w_sdata_nxt;
  logic [POS_W-1:0]       w_evt_pos;
  logic [PX_W-1:0]        w_pos_x;
  logic [WORD_LENGTH-1:0] w_load_l;
  logic [WORD_LENGTH-1:0] w_load_r;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_tx_en)  w_state_nxt = S_RUN;
      S_RUN:   if (!i_tx_en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_div_wrap = (r_state == S_RUN) && (r_div == DIV_LAST);
    w_event    = 1'b0;
    w_evt_pos  = '0;
    case (r_state)
      S_IDLE: w_event = i_tx_en;
      S_RUN: begin
        w_event   = i_tx_en && w_div_wrap && r_bclk;
        w_evt_pos = (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
      end
      default: w_event = 1'b0;
    endcase
    w_frame_start = w_event && (w_evt_pos == '0);
    w_accept      = i_tx_valid && !r_buf_full;
    w_load_l      = r_buf_full ? r_buf_l : '0;
    w_load_r      = r_buf_full ? r_buf_r : '0;
    w_pos_x       = {1'b0, w_evt_pos};
    w_in_left     = (w_pos_x < L_END);
    w_in_right    = (w_pos_x >= R_BEG) && (w_pos_x < R_END);
    w_ws_nxt      = (w_pos_x >= WS_BEG) && (w_pos_x <= WS_END);
    // The pos-0 bit comes straight from the buffer, so it is valid on the very first event.
    if (w_frame_start)   w_sdata_nxt = w_load_l[WORD_LENGTH-1];
    else if (w_in_left)  w_sdata_nxt = r_sh_l[WORD_LENGTH-1];
    else if (w_in_right) w_sdata_nxt = r_sh_r[WORD_LENGTH-1];
    else                 w_sdata_nxt = 1'b0;
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div      <= '0;
      r_pos      <= '0;
      r_bclk     <= 1'b0;
      r_ws       <= 1'b0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_buf_full <= 1'b0;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
    end else begin
      r_underrun <= w_frame_start && !r_buf_full;
      if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= i_tx_left_data;
        r_buf_r    <= i_tx_right_data;
      end else if (w_frame_start) begin
        r_buf_full <= 1'b0;
      end
      if (!i_tx_en) begin
        r_div   <= '0;
        r_pos   <= '0;
        r_bclk  <= 1'b0;
        r_ws    <= 1'b0;
        r_sdata <= 1'b0;
      end else begin
        if (r_state == S_RUN) r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
        if (w_div_wrap) r_bclk <= ~r_bclk;
        if (w_event) begin
          r_pos   <= w_evt_pos;
          r_ws    <= w_ws_nxt;
          r_sdata <= w_sdata_nxt;
          if (w_frame_start) begin
            r_sh_l <= w_load_l << 1;
            r_sh_r <= w_load_r;
          end else if (w_in_left) begin
            r_sh_l <= r_sh_l << 1;
          end else if (w_in_right) begin
            r_sh_r <= r_sh_r << 1;
          end
        end
      end
    end
  end

  assign o_tx_ready    = ~r_buf_full;
  assign o_tx_underrun = r_underrun;
  assign o_bclk        = r_bclk;
  assign o_ws          = r_ws;
  assign o_sdata       = r_sdata;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: per-cycle line model computed from frame arithmetic, plus a
// bit-counting receiver that rebuilds each frame from rising-edge samples.
module tb_i2s_tx;
  localparam int WL = 24;
  localparam int S  = 32;
  localparam int D  = 4;
  localparam int F  = 4 * S * D;

  typedef struct {
    bit            push;
    logic [WL-1:0] l;
    logic [WL-1:0] r;
    logic [WL-1:0] exp_l;
    logic [WL-1:0] exp_r;
    int            exp_und;
  } vec_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          en    = 1'b0;
  logic          valid = 1'b0;
  logic [WL-1:0] dl    = '0;
  logic [WL-1:0] dr    = '0;
  logic          ready, underrun, bclk, ws, sdata;

  i2s_tx #(.WORD_LENGTH(WL), .SLOT_BITS(S), .BCLK_DIV(D)) dut (
    .i_sys_clk       (clk),
    .i_rst           (rst),
    .i_tx_en         (en),
    .i_tx_valid      (valid),
    .o_tx_ready      (ready),
    .i_tx_left_data  (dl),
    .i_tx_right_data (dr),
    .o_tx_underrun   (underrun),
    .o_bclk          (bclk),
    .o_ws            (ws),
    .o_sdata         (sdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int cyc_no = 0;

  // reference model: run flag, cycles since the pos-0 event, abstract buffer, current frame data
  bit            m_run  = 1'b0;
  int            m_j    = 0;
  bit            m_full = 1'b0;
  logic [WL-1:0] m_bl = '0, m_br = '0, m_cl = '0, m_cr = '0;

  logic            prev_bclk = 1'b0;
  int              rx_cnt    = 0;
  logic [2*S-1:0]  rx_bits   = '0;
  logic [WL-1:0]   rx_l = '0, rx_r = '0;
  logic            rx_pad    = 1'b0;
  int              rx_frames = 0;
  int              und_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc_no, act, exp);
    end
  endtask

  function automatic logic fbit(input logic [WL-1:0] l, input logic [WL-1:0] r, input int p);
    if (p < WL) return l[WL-1-p];
    if (p >= S && p < S + WL) return r[WL-1-(p-S)];
    return 1'b0;
  endfunction

  task automatic cyc(input bit e, input bit v, input logic [WL-1:0] l, input logic [WL-1:0] r);
    bit   start, full_b, acc;
    int   h, p;
    logic e_bclk, e_ws, e_sd, e_und;
    en = e; valid = v; dl = l; dr = r;
    full_b = m_full;
    acc    = v && !full_b;
    start  = 1'b0;
    if (!e) m_run = 1'b0;
    else if (!m_run) begin m_run = 1'b1; m_j = 0; start = 1'b1; end
    else begin m_j++; start = ((m_j % F) == 0); end
    if (start) begin
      if (full_b) begin m_cl = m_bl; m_cr = m_br; m_full = 1'b0; end
      else begin m_cl = '0; m_cr = '0; end
    end
    if (acc) begin m_bl = l; m_br = r; m_full = 1'b1; end
    e_und = start && !full_b;
    e_bclk = 1'b0; e_ws = 1'b0; e_sd = 1'b0;
    if (m_run) begin
      h = m_j / D;
      p = (h / 2) % (2 * S);
      e_bclk = ((h % 2) == 1);
      e_ws   = (p >= S - 1) && (p <= 2 * S - 2);
      e_sd   = fbit(m_cl, m_cr, p);
    end
    @(posedge clk); #1;
    cyc_no++;
    check("lines bclk/ws/sd/rdy/und", 32'({bclk, ws, sdata, ready, underrun}),
          32'({e_bclk, e_ws, e_sd, !m_full, e_und}));
    if (!m_run) rx_cnt = 0;
    else if (!prev_bclk && bclk) begin
      rx_bits[2*S-1-rx_cnt] = sdata;
      rx_cnt++;
      if (rx_cnt == 2 * S) begin
        rx_l   = rx_bits[2*S-1 -: WL];
        rx_r   = rx_bits[S-1 -: WL];
        rx_pad = (|rx_bits[2*S-1-WL -: S-WL]) | (|rx_bits[S-WL-1:0]);
        rx_frames++;
        rx_cnt = 0;
      end
    end
    prev_bclk = bclk;
    if (underrun === 1'b1) und_cnt++;
  endtask

  task automatic run_frame(input bit push, input logic [WL-1:0] l, input logic [WL-1:0] r);
    for (int k = 0; k < F; k++) cyc(1'b1, push && (k == 10), l, r);
  endtask

  task automatic check_frame(input string tag, input logic [WL-1:0] el, input logic [WL-1:0] er,
                             input int eund, input int fb);
    check({tag, " left"},  32'(rx_l), 32'(el));
    check({tag, " right"}, 32'(rx_r), 32'(er));
    check({tag, " pad"},   32'(rx_pad), 32'(1'b0));
    check({tag, " underrun count"}, 32'(und_cnt), 32'(eund));
    check({tag, " frames received"}, 32'(rx_frames), 32'(fb + 1));
  endtask

  task automatic do_reset();
    en = 1'b0; valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst async lines", 32'({bclk, ws, sdata}), 32'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("rst release ready", 32'(ready), 32'(1));
    check("rst release underrun", 32'(underrun), 32'(0));
    m_run = 1'b0; m_full = 1'b0; prev_bclk = 1'b0; rx_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t          tbl[8];
    int            fb, b_acc_k, rdy_hi;
    bit            b_done, v, off;
    int            off_cnt;
    logic [WL-1:0] al, ar, bl, br, c_l, c_r;

    tbl[0] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 0};
    tbl[1] = '{1'b1, 24'h800001, 24'h7FFFFE, 24'h800001, 24'h7FFFFE, 0};
    tbl[2] = '{1'b1, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 0};
    tbl[3] = '{1'b0, 24'h111111, 24'h222222, 24'h000000, 24'h000000, 1};
    tbl[4] = '{1'b0, 24'h333333, 24'h444444, 24'h000000, 24'h000000, 1};
    tbl[5] = '{1'b1, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 0};
    tbl[6] = '{1'b1, 24'h000001, 24'h800000, 24'h000001, 24'h800000, 0};
    tbl[7] = '{1'b1, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 0};

    // power-on reset
    #1 rst = 1'b1;
    #2 check("reset lines/ready/underrun", 32'({bclk, ws, sdata, ready, underrun}), 32'(5'b00010));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("reset release ready", 32'(ready), 32'(1));

    // reset mid-frame with a sample buffered
    cyc(1'b0, 1'b1, 24'h0F0F0F, 24'hF0F0F0);
    for (int k = 0; k < 300; k++) cyc(1'b1, k == 10, 24'h333333, 24'hCCCCCC);
    check("pre-reset buffer full", 32'(ready), 32'(0));
    do_reset();

    // table-driven frames: entry i+1 is pushed during frame i
    cyc(1'b0, tbl[0].push, tbl[0].l, tbl[0].r);
    for (int i = 0; i < 8; i++) begin
      fb = rx_frames; und_cnt = 0;
      if (i < 7) run_frame(tbl[i+1].push, tbl[i+1].l, tbl[i+1].r);
      else       run_frame(1'b0, '0, '0);
      check_frame($sformatf("tbl[%0d]", i), tbl[i].exp_l, tbl[i].exp_r, tbl[i].exp_und, fb);
    end

    // back-to-back pushes: A accepted, B waits for the next frame start
    al = 24'hABCDEF; ar = 24'h135790; bl = 24'h876543; br = 24'h02468A;
    fb = rx_frames; und_cnt = 0; rdy_hi = 0;
    for (int k = 0; k < F; k++) begin
      if (k >= 11 && ready) rdy_hi++;
      if (k == 10)      cyc(1'b1, 1'b1, al, ar);
      else if (k > 10)  cyc(1'b1, 1'b1, bl, br);
      else              cyc(1'b1, 1'b0, '0, '0);
    end
    check_frame("b2b empty frame", '0, '0, 1, fb);
    check("b2b ready high while holding", 32'(rdy_hi), 32'(0));
    fb = rx_frames; und_cnt = 0; b_done = 1'b0; b_acc_k = -1;
    for (int k = 0; k < F; k++) begin
      v = !b_done;
      if (v && ready) begin b_acc_k = k; b_done = 1'b1; end
      cyc(1'b1, v, bl, br);
    end
    check("b2b second accept cycle", 32'(b_acc_k), 32'(1));
    check_frame("b2b frame A", al, ar, 0, fb);
    fb = rx_frames; und_cnt = 0;
    run_frame(1'b0, '0, '0);
    check_frame("b2b frame B", bl, br, 0, fb);

    // disable mid-right-slot with a sample buffered, then re-enable
    c_l = 24'hA5C3E1; c_r = 24'h5A3C1E;
    for (int k = 0; k < 323; k++) cyc(1'b1, k == 10, c_l, c_r);
    check("ws high in right slot", 32'(ws), 32'(1));
    cyc(1'b0, 1'b0, '0, '0);
    check("disable lines idle", 32'({bclk, ws, sdata}), 32'(0));
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, '0, '0);
    check("disable keeps buffer", 32'(ready), 32'(0));
    fb = rx_frames; und_cnt = 0;
    cyc(1'b1, 1'b0, '0, '0);
    check("re-enable left MSB", 32'(sdata), 32'(c_l[WL-1]));
    check("re-enable ready", 32'(ready), 32'(1));
    for (int k = 1; k < F; k++) cyc(1'b1, 1'b0, '0, '0);
    check_frame("re-enable frame", c_l, c_r, 0, fb);

    // randomized traffic with occasional disables, checked against the line model
    off_cnt = 0; v = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      off = 1'b0;
      if (off_cnt > 0) begin off_cnt--; off = 1'b1; end
      else if ($urandom_range(0, 1499) == 0) begin off_cnt = $urandom_range(1, 20); off = 1'b1; end
      v = ($urandom_range(0, 149) == 0);
      cyc(!off, v, WL'($urandom), WL'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
